multi_stride_detector: RTL and testbench

MULTI_STRIDE_DETECTOR -- requirements
Module: multi_stride_detector

---
 rtl/multi_stride_detector.sv | 253 +++++++++++++++++++++++++
 tb/tb_multi_stride_detector.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_stride_detector.sv
// rtl/multi_stride_detector.sv - per-ID stride prefetcher snooping an AXI read-address channel
//
// Learns a constant address stride per AXI ID from snooped demand reads and
// issues prefetch requests ahead of each trained stream.
//
// Ports:
//   clk, resetN          clock, asynchronous active-low reset
//   en                   global enable (freezes training and new grants when low)
//   s_ar_valid/ready     snooped demand handshake; s_ar_addr / s_ar_id demand payload
//   pf_valid/pf_ready    prefetch request handshake; pf_addr/pf_id/pf_stream payload
//   flush_valid          one-cycle pulse when an ACTIVE entry breaks stride or is evicted
//   flush_stream         entry index for flush_valid
//   bar, limit           legal prefetch window [bar, limit)
//   crs_conf_thresh      training confidence threshold
//   crs_pf_depth         max outstanding prefetches per entry
module multi_stride_detector #(
  parameter int ADDR_BITS   = 16,
  parameter int LOG_STREAMS = 2,
  parameter int TID_WIDTH   = 8,
  parameter int CONF_WIDTH  = 3,
  parameter int DEPTH_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   en,
  input  logic                   s_ar_valid,
  input  logic                   s_ar_ready,
  input  logic [ADDR_BITS-1:0]   s_ar_addr,
  input  logic [TID_WIDTH-1:0]   s_ar_id,
  output logic                   pf_valid,
  input  logic                   pf_ready,
  output logic [ADDR_BITS-1:0]   pf_addr,
  output logic [TID_WIDTH-1:0]   pf_id,
  output logic [LOG_STREAMS-1:0] pf_stream,
  output logic                   flush_valid,
  output logic [LOG_STREAMS-1:0] flush_stream,
  input  logic [ADDR_BITS-1:0]   bar,
  input  logic [ADDR_BITS-1:0]   limit,
  input  logic [CONF_WIDTH-1:0]  crs_conf_thresh,
  input  logic [DEPTH_WIDTH-1:0] crs_pf_depth
);

  localparam int NUM_STREAMS = 1 << LOG_STREAMS;

  typedef enum logic [1:0] {ST_IDLE, ST_TRAIN, ST_ACTIVE} state_t;

  state_t                 st_q     [NUM_STREAMS];
  logic [TID_WIDTH-1:0]   id_q     [NUM_STREAMS];
  logic [ADDR_BITS-1:0]   last_q   [NUM_STREAMS];
  logic [ADDR_BITS-1:0]   stride_q [NUM_STREAMS];
  logic [ADDR_BITS-1:0]   next_q   [NUM_STREAMS];
  logic [CONF_WIDTH-1:0]  conf_q   [NUM_STREAMS];
  logic [DEPTH_WIDTH-1:0] issued_q [NUM_STREAMS];

  logic [LOG_STREAMS-1:0] victim_q;
  logic [LOG_STREAMS-1:0] last_gnt_q;
  logic [LOG_STREAMS-1:0] gnt_idx_q;
  // Cleared when the granted entry is retrained or reallocated while its
  // request is outstanding, so the eventual handshake does not touch it.
  logic                   gnt_live_q;

  // Demand lookup
  logic                   dem;
  logic                   hit;
  logic [LOG_STREAMS-1:0] hit_idx;
  logic                   idle_found;
  logic [LOG_STREAMS-1:0] idle_idx;
  logic [LOG_STREAMS-1:0] tgt_idx;
  logic                   use_victim;
  logic [ADDR_BITS-1:0]   delta;
  logic                   match;
  logic [CONF_WIDTH-1:0]  conf_inc;
  logic                   activate;
  logic                   retrain;
  logic                   flush_set;

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    idle_found = 1'b0;
    idle_idx   = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (st_q[i] != ST_IDLE && id_q[i] == s_ar_id && !hit) begin
        hit     = 1'b1;
        hit_idx = LOG_STREAMS'(i);
      end
      if (st_q[i] == ST_IDLE && !idle_found) begin
        idle_found = 1'b1;
        idle_idx   = LOG_STREAMS'(i);
      end
    end
  end

  assign dem        = en && s_ar_valid && s_ar_ready;
  assign tgt_idx    = hit ? hit_idx : (idle_found ? idle_idx : victim_q);
  assign use_victim = dem && !hit && !idle_found;
  assign delta      = s_ar_addr - last_q[tgt_idx];
  assign match      = hit && (delta == stride_q[tgt_idx]) && (delta != '0);
  assign conf_inc   = (conf_q[tgt_idx] == '1) ? conf_q[tgt_idx]
                                              : conf_q[tgt_idx] + CONF_WIDTH'(1);
  // The access that established the stride counts as its first observation,
  // so the number of consistent deltas seen is conf + 1.
  assign activate   = match && (st_q[tgt_idx] == ST_TRAIN) &&
                      (({1'b0, conf_inc} + (CONF_WIDTH+1)'(1)) >= {1'b0, crs_conf_thresh});
  // Allocation or stride break wipes the entry's training and prefetch state.
  assign retrain    = dem && !match;
  // An idle allocation target is never ACTIVE, so this only fires on stride
  // break or victim eviction of an ACTIVE entry.
  assign flush_set  = retrain && (st_q[tgt_idx] == ST_ACTIVE);

  // Prefetch arbitration
  logic [NUM_STREAMS-1:0] elig;
  logic                   hs;
  logic                   pf_inc;
  logic                   gnt;
  logic [LOG_STREAMS-1:0] gnt_idx;
  logic [LOG_STREAMS-1:0] arb_cand;

  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      elig[i] = (st_q[i] == ST_ACTIVE) && (issued_q[i] < crs_pf_depth) &&
                (next_q[i] >= bar) && (next_q[i] < limit);
    end
  end

  always_comb begin
    gnt      = 1'b0;
    gnt_idx  = '0;
    arb_cand = '0;
    // Search starts one past the last grant; the final step wraps back to it.
    for (int k = 1; k <= NUM_STREAMS; k++) begin
      arb_cand = last_gnt_q + LOG_STREAMS'(k);
      if (elig[arb_cand] && !gnt) begin
        gnt     = 1'b1;
        gnt_idx = arb_cand;
      end
    end
    // Only one request is ever outstanding; a new grant waits for the slot.
    if (!en || pf_valid) begin
      gnt = 1'b0;
    end
  end

  assign hs     = pf_valid && pf_ready;
  assign pf_inc = hs && gnt_live_q;

  // Per-entry update strobes
  logic [NUM_STREAMS-1:0] sel_dem;
  logic [NUM_STREAMS-1:0] sel_clr;
  logic [NUM_STREAMS-1:0] sel_inc;
  logic [NUM_STREAMS-1:0] sel_dec;

  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      sel_dem[i] = dem && (tgt_idx == LOG_STREAMS'(i));
      sel_clr[i] = retrain && (tgt_idx == LOG_STREAMS'(i));
      sel_inc[i] = pf_inc && (gnt_idx_q == LOG_STREAMS'(i));
      sel_dec[i] = sel_dem[i] && match && (st_q[i] == ST_ACTIVE);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        st_q[i]     <= ST_IDLE;
        id_q[i]     <= '0;
        last_q[i]   <= '0;
        stride_q[i] <= '0;
        next_q[i]   <= '0;
        conf_q[i]   <= '0;
        issued_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        if (sel_dem[i]) begin
          last_q[i] <= s_ar_addr;
          if (!hit) begin
            st_q[i]     <= ST_TRAIN;
            id_q[i]     <= s_ar_id;
            stride_q[i] <= '0;
            conf_q[i]   <= '0;
          end else if (!match) begin
            st_q[i]     <= ST_TRAIN;
            stride_q[i] <= delta;
            conf_q[i]   <= '0;
          end else begin
            conf_q[i] <= conf_inc;
            if (activate) begin
              st_q[i] <= ST_ACTIVE;
            end
          end
        end

        if (sel_dem[i] && activate) begin
          next_q[i] <= s_ar_addr + stride_q[i];
        end else if (sel_inc[i] && !sel_clr[i]) begin
          next_q[i] <= next_q[i] + stride_q[i];
        end

        // Demand consumption and prefetch issue on the same cycle cancel out.
        if (sel_clr[i]) begin
          issued_q[i] <= '0;
        end else if (sel_inc[i] && !sel_dec[i]) begin
          if (issued_q[i] != '1) issued_q[i] <= issued_q[i] + DEPTH_WIDTH'(1);
        end else if (sel_dec[i] && !sel_inc[i]) begin
          if (issued_q[i] != '0) issued_q[i] <= issued_q[i] - DEPTH_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      victim_q     <= '0;
      last_gnt_q   <= '0;
      gnt_idx_q    <= '0;
      gnt_live_q   <= 1'b0;
      pf_valid     <= 1'b0;
      pf_addr      <= '0;
      pf_id        <= '0;
      pf_stream    <= '0;
      flush_valid  <= 1'b0;
      flush_stream <= '0;
    end else begin
      if (use_victim) begin
        victim_q <= victim_q + LOG_STREAMS'(1);
      end

      flush_valid <= flush_set;
      if (flush_set) begin
        flush_stream <= tgt_idx;
      end

      if (gnt) begin
        pf_valid   <= 1'b1;
        pf_addr    <= next_q[gnt_idx];
        pf_id      <= id_q[gnt_idx];
        pf_stream  <= gnt_idx;
        gnt_idx_q  <= gnt_idx;
        last_gnt_q <= gnt_idx;
        gnt_live_q <= !(retrain && tgt_idx == gnt_idx);
      end else begin
        if (hs) begin
          pf_valid <= 1'b0;
        end
        if (retrain && tgt_idx == gnt_idx_q) begin
          gnt_live_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_stride_detector.sv
// tb/tb_multi_stride_detector.sv - directed self-checking bench for multi_stride_detector
module tb_multi_stride_detector;

  logic        clk = 1'b0;
  logic        resetN;
  logic        en;
  logic        s_ar_valid;
  logic        s_ar_ready;
  logic [15:0] s_ar_addr;
  logic [7:0]  s_ar_id;
  logic        pf_valid;
  logic        pf_ready;
  logic [15:0] pf_addr;
  logic [7:0]  pf_id;
  logic [1:0]  pf_stream;
  logic        flush_valid;
  logic [1:0]  flush_stream;
  logic [15:0] bar;
  logic [15:0] limit;
  logic [2:0]  crs_conf_thresh;
  logic [2:0]  crs_pf_depth;

  int checks   = 0;
  int failures = 0;

  logic [15:0] got_addr[$];
  logic [7:0]  got_id[$];
  logic [1:0]  got_stream[$];

  multi_stride_detector dut (
    .clk             (clk),
    .resetN          (resetN),
    .en              (en),
    .s_ar_valid      (s_ar_valid),
    .s_ar_ready      (s_ar_ready),
    .s_ar_addr       (s_ar_addr),
    .s_ar_id         (s_ar_id),
    .pf_valid        (pf_valid),
    .pf_ready        (pf_ready),
    .pf_addr         (pf_addr),
    .pf_id           (pf_id),
    .pf_stream       (pf_stream),
    .flush_valid     (flush_valid),
    .flush_stream    (flush_stream),
    .bar             (bar),
    .limit           (limit),
    .crs_conf_thresh (crs_conf_thresh),
    .crs_pf_depth    (crs_pf_depth)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    resetN          = 1'b0;
    en              = 1'b1;
    s_ar_valid      = 1'b0;
    s_ar_ready      = 1'b0;
    s_ar_addr       = '0;
    s_ar_id         = '0;
    pf_ready        = 1'b0;
    bar             = 16'h0000;
    limit           = 16'h1DDE;
    crs_conf_thresh = 3'd2;
    crs_pf_depth    = 3'd3;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // Drives one demand beat; returns on the negedge after the capturing posedge.
  task automatic demand(input logic [7:0] id, input logic [15:0] addr);
    @(negedge clk);
    s_ar_valid = 1'b1;
    s_ar_ready = 1'b1;
    s_ar_id    = id;
    s_ar_addr  = addr;
    @(negedge clk);
    s_ar_valid = 1'b0;
    s_ar_ready = 1'b0;
  endtask

  // Records prefetch handshakes, sampling the current negedge first.
  task automatic collect(input int max_cycles, input int stop_after);
    got_addr.delete();
    got_id.delete();
    got_stream.delete();
    for (int c = 0; c < max_cycles; c++) begin
      if (pf_valid && pf_ready) begin
        got_addr.push_back(pf_addr);
        got_id.push_back(pf_id);
        got_stream.push_back(pf_stream);
        if (got_addr.size() == stop_after) begin
          @(negedge clk);
          return;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    en = 1'b1; s_ar_valid = 1'b0; s_ar_ready = 1'b0; s_ar_addr = '0; s_ar_id = '0;
    pf_ready = 1'b0; bar = '0; limit = 16'h1DDE; crs_conf_thresh = 3'd2; crs_pf_depth = 3'd3;
    @(negedge clk);
    checks++;
    if ({pf_valid, flush_valid} !== 2'b00) begin
      failures++; $display("FAIL reset_valids got=%b exp=00", {pf_valid, flush_valid});
    end
    checks++;
    if ({pf_addr, pf_id, pf_stream, flush_stream} !== 28'h0) begin
      failures++; $display("FAIL reset_payload got=%h exp=0", {pf_addr, pf_id, pf_stream, flush_stream});
    end
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_train_and_depth();
    do_reset();
    pf_ready = 1'b1;
    demand(8'd5, 16'h0EEF);
    demand(8'd5, 16'h0EF2);
    demand(8'd5, 16'h0EF5);
    checks++;
    if (pf_valid !== 1'b0) begin
      failures++; $display("FAIL latency_early got=%b exp=0", pf_valid);
    end
    @(negedge clk);
    checks++;
    if (pf_valid !== 1'b1) begin
      failures++; $display("FAIL latency_two got=%b exp=1", pf_valid);
    end
    collect(20, 100);
    checks++;
    if (got_addr.size() != 3) begin
      failures++; $display("FAIL depth_count got=%0d exp=3", got_addr.size());
    end else begin
      checks++;
      if ({got_addr[0], got_addr[1], got_addr[2]} !== {16'h0EF8, 16'h0EFB, 16'h0EFE}) begin
        failures++; $display("FAIL pf_addrs got=%h %h %h exp=0ef8 0efb 0efe", got_addr[0], got_addr[1], got_addr[2]);
      end
      checks++;
      if ({got_id[0], got_stream[0]} !== {8'd5, 2'd0}) begin
        failures++; $display("FAIL pf_id_stream got=%h/%0d exp=05/0", got_id[0], got_stream[0]);
      end
    end
    // A matching demand consumes one outstanding prefetch and frees one slot.
    demand(8'd5, 16'h0EF8);
    collect(20, 100);
    checks++;
    if (got_addr.size() != 1 || got_addr[0] !== 16'h0F01) begin
      failures++; $display("FAIL refill got=%0d@%h exp=1@0f01", got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : 16'hxxxx);
    end
  endtask

  task automatic test_stride_break();
    demand(8'd5, 16'h0EEF);
    checks++;
    if ({flush_valid, flush_stream} !== {1'b1, 2'd0}) begin
      failures++; $display("FAIL break_flush got=%b/%0d exp=1/0", flush_valid, flush_stream);
    end
    @(negedge clk);
    checks++;
    if (flush_valid !== 1'b0) begin
      failures++; $display("FAIL break_pulse got=%b exp=0", flush_valid);
    end
    collect(10, 100);
    checks++;
    if (got_addr.size() != 0) begin
      failures++; $display("FAIL break_quiet got=%0d exp=0", got_addr.size());
    end
    demand(8'd5, 16'h0EF2);
    demand(8'd5, 16'h0EF5);
    collect(20, 100);
    checks++;
    if (got_addr.size() != 3 || got_addr[0] !== 16'h0EF8) begin
      failures++; $display("FAIL retrain got=%0d first=%h exp=3 first=0ef8", got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : 16'hxxxx);
    end
  endtask

  task automatic test_eviction();
    logic [7:0] ids[4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    do_reset();
    pf_ready = 1'b1;
    demand(8'd1, 16'h0100);
    demand(8'd1, 16'h0104);
    demand(8'd1, 16'h0108);
    for (int i = 1; i < 4; i++) begin
      demand(ids[i], 16'(ids[i]) << 8);
      checks++;
      if (flush_valid !== 1'b0) begin
        failures++; $display("FAIL fill_noflush id=%0d got=%b exp=0", ids[i], flush_valid);
      end
    end
    demand(8'd5, 16'h0500);
    checks++;
    if ({flush_valid, flush_stream} !== {1'b1, 2'd0}) begin
      failures++; $display("FAIL evict_flush got=%b/%0d exp=1/0", flush_valid, flush_stream);
    end
    demand(8'd6, 16'h0600);
    checks++;
    if (flush_valid !== 1'b0) begin
      failures++; $display("FAIL evict_train_noflush got=%b exp=0", flush_valid);
    end
    demand(8'd6, 16'h0610);
    demand(8'd6, 16'h0620);
    collect(20, 1);
    checks++;
    if (got_addr.size() != 1 || {got_addr[0], got_id[0], got_stream[0]} !== {16'h0630, 8'd6, 2'd1}) begin
      failures++; $display("FAIL victim_ptr got=%0d exp=1 pf 0630/06/1", got_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_a[4] = '{16'h010C, 16'h0830, 16'h0110, 16'h0840};
    logic [1:0]  exp_s[4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    do_reset();
    crs_pf_depth = 3'd7;
    demand(8'h11, 16'h0100);
    demand(8'h11, 16'h0104);
    demand(8'h11, 16'h0108);
    demand(8'h22, 16'h0800);
    demand(8'h22, 16'h0810);
    demand(8'h22, 16'h0820);
    checks++;
    if ({pf_valid, pf_addr, pf_stream} !== {1'b1, 16'h010C, 2'd0}) begin
      failures++; $display("FAIL pending got=%b/%h/%0d exp=1/010c/0", pf_valid, pf_addr, pf_stream);
    end
    pf_ready = 1'b1;
    collect(30, 4);
    pf_ready = 1'b0;
    checks++;
    if (got_addr.size() != 4) begin
      failures++; $display("FAIL rr_count got=%0d exp=4", got_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({got_addr[i], got_stream[i]} !== {exp_a[i], exp_s[i]}) begin
          failures++; $display("FAIL rr_grant%0d got=%h/%0d exp=%h/%0d", i, got_addr[i], got_stream[i], exp_a[i], exp_s[i]);
        end
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({pf_valid, pf_addr, pf_id, pf_stream} !== {1'b1, 16'h0114, 8'h11, 2'd0}) begin
        failures++; $display("FAIL hold%0d got=%b/%h/%h/%0d exp=1/0114/11/0", c, pf_valid, pf_addr, pf_id, pf_stream);
      end
    end
    en = 1'b0;
    pf_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (pf_valid !== 1'b0) begin
        failures++; $display("FAIL en_low_drain%0d got=%b exp=0", c, pf_valid);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_window();
    do_reset();
    limit = 16'h0100;
    pf_ready = 1'b1;
    demand(8'd9, 16'h00F6);
    demand(8'd9, 16'h00F9);
    demand(8'd9, 16'h00FC);
    collect(15, 100);
    checks++;
    if (got_addr.size() != 1 || got_addr[0] !== 16'h00FF) begin
      failures++; $display("FAIL window_limit got=%0d first=%h exp=1 first=00ff", got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : 16'hxxxx);
    end
    bar = 16'h0001;
    demand(8'd10, 16'h000B);
    demand(8'd10, 16'h0008);
    demand(8'd10, 16'h0005);
    collect(15, 100);
    checks++;
    if (got_addr.size() != 1 || {got_addr[0], got_stream[0]} !== {16'h0002, 2'd1}) begin
      failures++; $display("FAIL window_wrap got=%0d exp=1 pf 0002/1", got_addr.size());
    end
  endtask

  task automatic test_enable();
    do_reset();
    pf_ready = 1'b1;
    en = 1'b0;
    demand(8'd7, 16'h0020);
    demand(8'd7, 16'h0024);
    demand(8'd7, 16'h0028);
    collect(8, 100);
    checks++;
    if (got_addr.size() != 0) begin
      failures++; $display("FAIL en_low_train got=%0d exp=0", got_addr.size());
    end
    en = 1'b1;
    demand(8'd7, 16'h002C);
    collect(8, 100);
    checks++;
    if (got_addr.size() != 0) begin
      failures++; $display("FAIL en_low_ignored got=%0d exp=0", got_addr.size());
    end
  endtask

  task automatic test_reset_mid_handshake();
    do_reset();
    demand(8'd3, 16'h0040);
    demand(8'd3, 16'h0044);
    demand(8'd3, 16'h0048);
    @(negedge clk);
    checks++;
    if (pf_valid !== 1'b1) begin
      failures++; $display("FAIL pre_reset_valid got=%b exp=1", pf_valid);
    end
    #2 resetN = 1'b0;
    #1;
    checks++;
    if ({pf_valid, pf_addr} !== {1'b0, 16'h0000}) begin
      failures++; $display("FAIL async_reset got=%b/%h exp=0/0000", pf_valid, pf_addr);
    end
    @(negedge clk);
    resetN = 1'b1;
    pf_ready = 1'b1;
    collect(8, 100);
    checks++;
    if (got_addr.size() != 0) begin
      failures++; $display("FAIL post_reset_quiet got=%0d exp=0", got_addr.size());
    end
    demand(8'd3, 16'h004C);
    collect(8, 100);
    checks++;
    if (got_addr.size() != 0) begin
      failures++; $display("FAIL post_reset_idle got=%0d exp=0", got_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_train_and_depth();
    test_stride_break();
    test_eviction();
    test_back_to_back();
    test_window();
    test_enable();
    test_reset_mid_handshake();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
